// File: rtl/iob_axis_pack.sv
// Packs RATIO narrow AXI-Stream beats into one wide word, little-endian lanes.
// A tlast beat closes the word early with zero upper lanes.
module iob_axis_pack #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             cke_i,
  input  logic             rst_i,
  input  logic [IN_W-1:0]  axis_in_tdata_i,
  input  logic             axis_in_tvalid_i,
  input  logic             axis_in_tlast_i,
  output logic             axis_in_tready_o,
  output logic [OUT_W-1:0] axis_out_tdata_o,
  output logic             axis_out_tvalid_o,
  output logic             axis_out_tlast_o,
  input  logic             axis_out_tready_i,
  output logic [31:0]      word_cnt_o
);
  localparam int RATIO = OUT_W / IN_W;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [LW-1:0]    lane_q, lane_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [31:0]      cnt_q, cnt_d;

  logic [OUT_W-1:0] beat_word;
  logic             in_fire, out_fire, complete;

  assign axis_in_tready_o  = ~valid_q | axis_out_tready_i;
  assign axis_out_tdata_o  = data_q;
  assign axis_out_tvalid_o = valid_q;
  assign axis_out_tlast_o  = last_q;
  assign word_cnt_o        = cnt_q;

  assign in_fire  = cke_i & axis_in_tvalid_i & axis_in_tready_o;
  assign out_fire = cke_i & valid_q & axis_out_tready_i;
  assign complete = in_fire & ((lane_q == LW'(RATIO - 1)) | axis_in_tlast_i);

  // Current beat placed in its lane, zeros elsewhere.
  always_comb begin
    beat_word = '0;
    for (int k = 0; k < RATIO; k++)
      if (lane_q == LW'(k)) beat_word[k*IN_W +: IN_W] = axis_in_tdata_i;
  end

  always_comb begin
    lane_d  = lane_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (cke_i) begin
      if (rst_i) begin
        lane_d  = '0;
        acc_d   = '0;
        data_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        cnt_d   = '0;
      end else begin
        if (out_fire) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 32'd1;
        end
        // in_fire implies the output slot is empty or draining this cycle.
        if (complete) begin
          data_d  = acc_q | beat_word;
          valid_d = 1'b1;
          last_d  = axis_in_tlast_i;
          acc_d   = '0;
          lane_d  = '0;
        end else if (in_fire) begin
          acc_d  = acc_q | beat_word;
          lane_d = lane_q + LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      lane_q  <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      lane_q  <= lane_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_iob_axis_pack.sv
// Directed bench for iob_axis_pack (8 -> 32) with a word scoreboard.
module tb_iob_axis_pack;
  logic        clk = 1'b0;
  logic        arst, cke, rst;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_ready;
  logic [31:0] out_data;
  logic        out_valid, out_last, out_ready;
  logic [31:0] word_cnt;

  int errors = 0;
  int checks = 0;
  int stalls = 0;
  int exp_cnt = 0;
  logic [32:0] exp_q[$];
  logic [31:0] m_acc;
  int          m_lane;

  iob_axis_pack #(.IN_W(8), .OUT_W(32)) dut (
    .clk_i(clk), .arst_i(arst), .cke_i(cke), .rst_i(rst),
    .axis_in_tdata_i(in_data), .axis_in_tvalid_i(in_valid),
    .axis_in_tlast_i(in_last), .axis_in_tready_o(in_ready),
    .axis_out_tdata_o(out_data), .axis_out_tvalid_o(out_valid),
    .axis_out_tlast_o(out_last), .axis_out_tready_i(out_ready),
    .word_cnt_o(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_acc = '0;
    m_lane = 0;
    exp_cnt = 0;
  endtask

  // Present one beat, wait (bounded) for acceptance, update the packing model.
  task automatic beat(input logic [7:0] d, input logic l);
    int n = 0;
    in_data = d; in_valid = 1'b1; in_last = l;
    @(negedge clk);
    while (!(cke && in_ready)) begin
      n++;
      if (n > 50) break;
      @(negedge clk);
    end
    if (n > 0) stalls++;
    if (n > 50) chk("accept_timeout", 64'(n), 0);
    else begin
      m_acc = m_acc | (32'(d) << (m_lane * 8));
      if (m_lane == 3 || l) begin
        exp_q.push_back({l, m_acc});
        m_acc = '0;
        m_lane = 0;
      end else m_lane++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Scoreboard: a transfer happens at the next rising edge.
  always @(negedge clk) begin
    if (!arst && cke && !rst && out_valid && out_ready) begin
      chk("sb_pending", 64'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("sb_tdata", 64'(out_data), 64'(e[31:0]));
        chk("sb_tlast", 64'(out_last), 64'(e[32]));
      end
      exp_cnt++;
    end
  end

  initial begin
    logic [31:0] held;
    int base;
    arst = 1'b1; cke = 1'b1; rst = 1'b0; out_ready = 1'b1;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_last", 64'(out_last), 0);
    chk("rst_cnt", 64'(word_cnt), 0);
    chk("rst_in_ready", 64'(in_ready), 1);
    @(negedge clk); arst = 1'b0;
    @(posedge clk); #1;

    // Full word, one cycle latency, count 0 -> 1
    beat(8'h11, 0); beat(8'h22, 0); beat(8'h33, 0); beat(8'h44, 0);
    chk("w1_valid", 64'(out_valid), 1);
    chk("w1_data", 64'(out_data), 64'h44332211);
    chk("w1_last", 64'(out_last), 0);
    chk("w1_cnt0", 64'(word_cnt), 0);
    @(posedge clk); #1;
    chk("w1_cnt1", 64'(word_cnt), 1);
    chk("w1_drop_valid", 64'(out_valid), 0);

    // Short packet, then single-beat packet
    beat(8'hAA, 0); beat(8'hBB, 1);
    chk("short_data", 64'(out_data), 64'h0000BBAA);
    chk("short_last", 64'(out_last), 1);
    beat(8'hCC, 1);
    chk("single_data", 64'(out_data), 64'h000000CC);
    chk("single_last", 64'(out_last), 1);
    repeat (2) @(posedge clk); #1;

    // Back-pressure hold for 5 cycles
    out_ready = 1'b0;
    beat(8'h55, 0); beat(8'h66, 0); beat(8'h77, 0); beat(8'h88, 0);
    held = out_data;
    base = int'(word_cnt);
    chk("hold_data0", 64'(held), 64'h88776655);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 64'(out_valid), 1);
      chk("hold_data", 64'(out_data), 64'(held));
      chk("hold_last", 64'(out_last), 0);
      chk("hold_in_ready", 64'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1 chk("release_in_ready", 64'(in_ready), 1);
    @(posedge clk); #1;
    chk("release_cnt", 64'(word_cnt), 64'(base + 1));
    @(posedge clk); #1;
    chk("release_cnt_once", 64'(word_cnt), 64'(base + 1));

    // Held word dropped by synchronous clear, not counted
    out_ready = 1'b0;
    beat(8'h01, 0); beat(8'h02, 1);
    rst = 1'b1; model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("clr_valid", 64'(out_valid), 0);
    chk("clr_cnt", 64'(word_cnt), 0);
    chk("clr_data", 64'(out_data), 0);
    out_ready = 1'b1;

    // 64-beat stream at full rate
    stalls = 0;
    for (int i = 0; i < 64; i++) beat(8'(i), i == 63);
    chk("stream_last", 64'(out_last), 1);
    chk("stream_data", 64'(out_data), 64'h3F3E3D3C);
    @(posedge clk); #1;
    chk("stream_stalls", 64'(stalls), 0);
    chk("stream_cnt", 64'(word_cnt), 16);

    // Async reset mid-word drops the partial word
    beat(8'hA1, 0); beat(8'hA2, 0);
    arst = 1'b1; model_clear();
    #2;
    chk("arst_cnt", 64'(word_cnt), 0);
    chk("arst_valid", 64'(out_valid), 0);
    arst = 1'b0;
    @(posedge clk); #1;
    beat(8'h01, 0); beat(8'h02, 0); beat(8'h03, 0);
    chk("arst_no_partial", 64'(out_valid), 0);
    beat(8'h04, 0);
    chk("arst_word", 64'(out_data), 64'h04030201);
    @(posedge clk); #1;

    // Clock enable low during beat 3
    beat(8'h61, 0); beat(8'h62, 0);
    base = int'(word_cnt);
    in_data = 8'h63; in_valid = 1'b1; cke = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("cke_no_word", 64'(out_valid), 0);
    chk("cke_cnt", 64'(word_cnt), 64'(base));
    cke = 1'b1;
    beat(8'h63, 0); beat(8'h64, 0);
    chk("cke_word", 64'(out_data), 64'h64636261);
    chk("cke_last", 64'(out_last), 0);
    repeat (3) @(posedge clk); #1;
    chk("cke_cnt_after", 64'(word_cnt), 64'(base + 1));
    chk("sb_drained", 64'(exp_q.size()), 0);
    chk("cnt_model", 64'(word_cnt), 64'(exp_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
